// File: rtl/dpbr_pkg.sv
// dpbr_pkg: shared widths, pointer type and pointer math
// for the dual-port BRAM stream reader.
package dpbr_pkg;

  localparam int DPBR_ADDR_W = 10;
  localparam int DPBR_DATA_W = 9;

  typedef logic [DPBR_ADDR_W:0] ptr_t;

  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/dpbr_pf_fifo.sv
// dpbr_pf_fifo: small register FIFO holding prefetched
// BRAM words in front of the output stream.
module dpbr_pf_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 9,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] cnt;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  assign valid = (cnt != '0);
  assign count = cnt;
  assign dout  = valid ? mem[head] : '0;

  // storage: written at the tail, contents need no reset
  always_ff @(posedge clk) begin
    if (push && !clr)
      mem[tail] <= din;
  end

  // head/tail/occupancy bookkeeping; clr empties the FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push)
        tail <= nxt(tail);
      if (pop)
        head <= nxt(head);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dpbr_stream_reader.sv
// dpbr_stream_reader: prefetches circular-buffer entries
// from BRAM port B and streams them out as valid/ready.
import dpbr_pkg::*;

module dpbr_stream_reader #(
  parameter int ADDR_W   = DPBR_ADDR_W,
  parameter int DATA_W   = DPBR_DATA_W,
  parameter int PF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W:0]   level,
  input  logic              flush,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_ceb,
  output logic              bram_web,
  input  logic [DATA_W-1:0] bram_dob,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int CW = $clog2(PF_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [ADDR_W:0] iss_ptr;
  logic [ADDR_W:0] rd_q;
  logic            inflight;
  logic [CW-1:0]   stored;
  logic [OW-1:0]   occ;
  logic            pop;
  logic            pending;
  logic            has_room;
  logic            issue;

  assign pop      = m_valid & m_ready;
  assign pending  = (iss_ptr != wr_ptr);
  assign occ      = OW'(stored) + OW'(inflight);
  assign has_room = occ < (OW'(PF_DEPTH) + OW'(pop));
  // resetn gate keeps the read strobe low while reset is held
  assign issue    = resetn & ~flush & pending & has_room;

  assign bram_ceb   = issue;
  assign bram_addrb = iss_ptr[ADDR_W-1:0];
  assign bram_web   = 1'b0;
  assign rd_ptr     = rd_q;
  assign level      = ptr_diff(wr_ptr, rd_q);

  // issue/consume pointers and the one-deep read pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iss_ptr  <= '0;
      rd_q     <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      iss_ptr  <= wr_ptr;
      rd_q     <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (issue)
        iss_ptr <= iss_ptr + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      inflight <= issue;
    end
  end

  dpbr_pf_fifo #(
    .DEPTH (PF_DEPTH),
    .W     (DATA_W)
  ) u_pf (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .push   (inflight & ~flush),
    .din    (bram_dob),
    .pop    (pop),
    .dout   (m_data),
    .valid  (m_valid),
    .count  (stored)
  );

endmodule
